// File: rtl/cpu_pkg.sv
// Shared widths and record types for the 16-bit core's writeback path.
package cpu_pkg;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned LQ_DEPTH = 2;

    // A register file write request.
    typedef struct packed {
        logic [ADDR_W-1:0] add;
        logic [DATA_W-1:0] val;
    } wb_req_t;

    // One load-queue slot; valid drops when a younger ALU write squashes it.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] add;
        logic [DATA_W-1:0] val;
    } lq_entry_t;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Bundle of ALU/load inputs, register file write port, forwarding and pending flags.
interface writeback_stage_if #(
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
    parameter int unsigned DATA_W = cpu_pkg::DATA_W
) ();

    logic              in_alu_valid;
    logic [ADDR_W-1:0] in_alu_add;
    logic [DATA_W-1:0] in_alu_val;

    logic              in_mem_valid;
    logic [ADDR_W-1:0] in_mem_add;
    logic [DATA_W-1:0] in_mem_val;
    logic              out_mem_ready;

    logic [ADDR_W-1:0] out_write_reg_add;
    logic [DATA_W-1:0] out_write_reg_val;
    logic              out_write_en;

    logic [ADDR_W-1:0] in_read_reg_1_add;
    logic [ADDR_W-1:0] in_read_reg_2_add;
    logic              out_fwd_1_hit;
    logic              out_fwd_2_hit;
    logic [DATA_W-1:0] out_fwd_1_val;
    logic [DATA_W-1:0] out_fwd_2_val;
    logic              out_pend_1;
    logic              out_pend_2;

    logic [7:0]        out_drop_cnt;

    // Upstream pipeline / decode side.
    modport master (
        output in_alu_valid, in_alu_add, in_alu_val,
        output in_mem_valid, in_mem_add, in_mem_val,
        input  out_mem_ready,
        input  out_write_reg_add, out_write_reg_val, out_write_en,
        output in_read_reg_1_add, in_read_reg_2_add,
        input  out_fwd_1_hit, out_fwd_2_hit, out_fwd_1_val, out_fwd_2_val,
        input  out_pend_1, out_pend_2,
        input  out_drop_cnt
    );

    // Writeback stage side.
    modport slave (
        input  in_alu_valid, in_alu_add, in_alu_val,
        input  in_mem_valid, in_mem_add, in_mem_val,
        output out_mem_ready,
        output out_write_reg_add, out_write_reg_val, out_write_en,
        input  in_read_reg_1_add, in_read_reg_2_add,
        output out_fwd_1_hit, out_fwd_2_hit, out_fwd_1_val, out_fwd_2_val,
        output out_pend_1, out_pend_2,
        output out_drop_cnt
    );

endinterface

// File: rtl/writeback_stage_load_queue.sv
// Circular load FIFO with per-entry valid bits, squash-by-address and
// pending-address match outputs.
module load_queue
    import cpu_pkg::*;
#(
    parameter  int unsigned DEPTH = cpu_pkg::LQ_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = cpu_pkg::cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  wb_req_t           push_req,
    input  logic              pop,
    input  logic              squash,
    input  logic [ADDR_W-1:0] squash_add,
    input  logic [ADDR_W-1:0] match_add_1,
    input  logic [ADDR_W-1:0] match_add_2,
    output lq_entry_t         head,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  squash_hits,
    output logic              pend_1,
    output logic              pend_2
);

    lq_entry_t        slots [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] offset [DEPTH];
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] kill;

    assign head  = slots[rd_ptr];
    assign count = cnt;

    // Classify slots: occupied-and-valid, and which of those the ALU squashes.
    always_comb begin
        live        = '0;
        kill        = '0;
        pend_1      = 1'b0;
        pend_2      = 1'b0;
        squash_hits = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset[i] = PTR_W'(i) - rd_ptr;
            live[i]   = (CNT_W'(offset[i]) < cnt) && slots[i].valid;
            kill[i]   = live[i] && squash && (slots[i].add == squash_add);
            pend_1    = pend_1 | (live[i] && (slots[i].add == match_add_1));
            pend_2    = pend_2 | (live[i] && (slots[i].add == match_add_2));
            squash_hits = squash_hits + CNT_W'(kill[i]);
        end
    end

    // Slot storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (kill[i]) begin
                    slots[i].valid <= 1'b0;
                end
            end
            if (pop) begin
                slots[rd_ptr].valid <= 1'b0;
                rd_ptr              <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                slots[wr_ptr] <= '{valid: 1'b1, add: push_req.add, val: push_req.val};
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: arbitrates ALU results and load results onto the
// single register file write port, with forwarding and pending-load flags.
module writeback_stage #(
    parameter int unsigned ADDR_W   = cpu_pkg::ADDR_W,
    parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
    parameter int unsigned LQ_DEPTH = cpu_pkg::LQ_DEPTH
) (
    input logic               in_clk,
    input logic               in_rst,
    writeback_stage_if.slave  bus
);

    import cpu_pkg::*;

    localparam int unsigned CNT_W = cnt_width(LQ_DEPTH);

    lq_entry_t         lq_head;
    logic [CNT_W-1:0]  lq_count;
    logic [CNT_W-1:0]  squash_hits;
    logic              lq_pend_1;
    logic              lq_pend_2;

    logic              mem_accept;
    logic              discard;
    logic              lq_push;
    logic              lq_pop;
    logic              sel_en;
    wb_req_t           sel_req;
    wb_req_t           mem_req;
    logic [9:0]        drop_sum;
    logic [7:0]        drop_next;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_add;
    logic [DATA_W-1:0] wr_val;
    logic [7:0]        drop_cnt;

    assign bus.out_mem_ready = (lq_count < CNT_W'(LQ_DEPTH)) && !in_rst;
    assign mem_accept        = bus.in_mem_valid && bus.out_mem_ready;
    assign mem_req           = '{add: bus.in_mem_add, val: bus.in_mem_val};
    // An accepted load to the register the ALU writes this cycle is already stale.
    assign discard           = mem_accept && bus.in_alu_valid && (bus.in_mem_add == bus.in_alu_add);

    // Strict-priority source selection: ALU, then queue head, then bypassed load.
    always_comb begin
        sel_en  = 1'b0;
        sel_req = '0;
        lq_push = 1'b0;
        lq_pop  = 1'b0;
        if (bus.in_alu_valid) begin
            sel_en  = 1'b1;
            sel_req = '{add: bus.in_alu_add, val: bus.in_alu_val};
            lq_push = mem_accept && !discard;
        end else if (lq_count != '0) begin
            lq_pop  = 1'b1;
            sel_en  = lq_head.valid;
            sel_req = '{add: lq_head.add, val: lq_head.val};
            lq_push = mem_accept;
        end else if (mem_accept) begin
            sel_en  = 1'b1;
            sel_req = mem_req;
        end
    end

    // Saturating squash counter update.
    always_comb begin
        drop_sum  = 10'(drop_cnt) + 10'(squash_hits) + 10'(discard);
        drop_next = (drop_sum > 10'd255) ? 8'hFF : drop_sum[7:0];
    end

    // Output register and drop counter; reset cancels any in-flight write.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            wr_en    <= 1'b0;
            wr_add   <= '0;
            wr_val   <= '0;
            drop_cnt <= '0;
        end else begin
            wr_en    <= sel_en;
            wr_add   <= sel_req.add;
            wr_val   <= sel_req.val;
            drop_cnt <= drop_next;
        end
    end

    assign bus.out_write_en      = wr_en;
    assign bus.out_write_reg_add = wr_add;
    assign bus.out_write_reg_val = wr_val;
    assign bus.out_drop_cnt      = drop_cnt;

    assign bus.out_fwd_1_hit = wr_en && (wr_add == bus.in_read_reg_1_add);
    assign bus.out_fwd_2_hit = wr_en && (wr_add == bus.in_read_reg_2_add);
    assign bus.out_fwd_1_val = wr_val;
    assign bus.out_fwd_2_val = wr_val;
    assign bus.out_pend_1    = lq_pend_1;
    assign bus.out_pend_2    = lq_pend_2;

    load_queue #(
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk         (in_clk),
        .rst         (in_rst),
        .push        (lq_push),
        .push_req    (mem_req),
        .pop         (lq_pop),
        .squash      (bus.in_alu_valid),
        .squash_add  (bus.in_alu_add),
        .match_add_1 (bus.in_read_reg_1_add),
        .match_add_2 (bus.in_read_reg_2_add),
        .head        (lq_head),
        .count       (lq_count),
        .squash_hits (squash_hits),
        .pend_1      (lq_pend_1),
        .pend_2      (lq_pend_2)
    );

endmodule
